// File: rtl/break_value_unit.sv
// rtl/break_value_unit.sv - multi-candidate WalkSAT break-value engine
//
// Purpose:
//   Latches one break-clause mask per candidate variable, popcounts every mask
//   CHUNK_WIDTH bits per cycle, then picks the minimum-break candidate (lowest
//   index on ties) and flags the zero-break (freebie) case.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   start_i        request strobe, taken only while ready_o=1
//   clause_i       flattened masks, candidate k at [k*NUM_CLAUSES +: NUM_CLAUSES]
//   ack_i          consumer acknowledge, honoured only while valid_o=1
//   ready_o        high in IDLE
//   valid_o        high in DONE
//   break_values_o per-candidate break values, flattened like clause_i
//   min_break_o    minimum break value
//   min_idx_o      index of the minimum-break candidate
//   zero_break_o   min_break_o == 0

module break_value_unit #(
  parameter int NUM_CLAUSES      = 20,
  parameter int NUM_CANDIDATES   = 3,
  parameter int CHUNK_WIDTH      = 8,
  parameter int NUM_CLAUSES_BITS = 5,
  parameter int CAND_BITS        = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start_i,
  input  logic [NUM_CANDIDATES*NUM_CLAUSES-1:0]      clause_i,
  input  logic                                       ack_i,
  output logic                                       ready_o,
  output logic                                       valid_o,
  output logic [NUM_CANDIDATES*NUM_CLAUSES_BITS-1:0] break_values_o,
  output logic [NUM_CLAUSES_BITS-1:0]                min_break_o,
  output logic [CAND_BITS-1:0]                       min_idx_o,
  output logic                                       zero_break_o
);

  localparam int NUM_CHUNKS     = (NUM_CLAUSES + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  // Masks are stored zero-padded to a whole number of chunks.
  localparam int PAD_WIDTH      = NUM_CHUNKS * CHUNK_WIDTH;
  localparam int CHUNK_CNT_BITS = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SELECT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [NUM_CANDIDATES-1:0][PAD_WIDTH-1:0]        mask_q;
  logic [NUM_CANDIDATES-1:0][NUM_CLAUSES_BITS-1:0] acc_q;
  logic [NUM_CANDIDATES-1:0][NUM_CLAUSES_BITS-1:0] chunk_count;
  logic [CHUNK_CNT_BITS-1:0]                       chunk_q;
  logic                                            last_chunk;

  logic [NUM_CANDIDATES*NUM_CLAUSES_BITS-1:0] break_values_q;
  logic [NUM_CLAUSES_BITS-1:0]                min_break_q;
  logic [CAND_BITS-1:0]                       min_idx_q;
  logic                                       zero_break_q;

  logic [NUM_CLAUSES_BITS-1:0] scan_min;
  logic [CAND_BITS-1:0]        scan_idx;

  function automatic logic [NUM_CLAUSES_BITS-1:0] popcount(
    input logic [CHUNK_WIDTH-1:0] v
  );
    logic [NUM_CLAUSES_BITS-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      cnt = cnt + NUM_CLAUSES_BITS'(v[i]);
    end
    return cnt;
  endfunction

  assign last_chunk = (chunk_q == CHUNK_CNT_BITS'(NUM_CHUNKS - 1));

  // The mask register shifts down one chunk per COUNT cycle, so the chunk
  // being counted is always the low CHUNK_WIDTH bits.
  always_comb begin
    chunk_count = '0;
    for (int k = 0; k < NUM_CANDIDATES; k++) begin
      chunk_count[k] = popcount(mask_q[k][CHUNK_WIDTH-1:0]);
    end
  end

  // Strict less-than keeps the earliest candidate on ties.
  always_comb begin
    scan_min = acc_q[0];
    scan_idx = '0;
    for (int k = 1; k < NUM_CANDIDATES; k++) begin
      if (acc_q[k] < scan_min) begin
        scan_min = acc_q[k];
        scan_idx = CAND_BITS'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (last_chunk) begin
          state_d = SELECT;
        end
      end
      SELECT: begin
        state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q         <= '0;
      acc_q          <= '0;
      chunk_q        <= '0;
      break_values_q <= '0;
      min_break_q    <= '0;
      min_idx_q      <= '0;
      zero_break_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            for (int k = 0; k < NUM_CANDIDATES; k++) begin
              mask_q[k] <= PAD_WIDTH'(clause_i[k*NUM_CLAUSES +: NUM_CLAUSES]);
            end
            acc_q   <= '0;
            chunk_q <= '0;
          end
        end
        COUNT: begin
          for (int k = 0; k < NUM_CANDIDATES; k++) begin
            acc_q[k]  <= acc_q[k] + chunk_count[k];
            mask_q[k] <= mask_q[k] >> CHUNK_WIDTH;
          end
          chunk_q <= chunk_q + CHUNK_CNT_BITS'(1);
        end
        SELECT: begin
          for (int k = 0; k < NUM_CANDIDATES; k++) begin
            break_values_q[k*NUM_CLAUSES_BITS +: NUM_CLAUSES_BITS] <= acc_q[k];
          end
          min_break_q  <= scan_min;
          min_idx_q    <= scan_idx;
          zero_break_q <= (scan_min == '0);
        end
        default: begin
          // DONE: results hold until the next SELECT.
        end
      endcase
    end
  end

  assign break_values_o = break_values_q;
  assign min_break_o    = min_break_q;
  assign min_idx_o      = min_idx_q;
  assign zero_break_o   = zero_break_q;

endmodule

// File: doc/break_value_unit.md
Name: break_value_unit

Overview:
- Multi-candidate break-value engine for the WalkSAT flip-selection stage; successor to the single-row break counter.
- Accepts one break-clause mask per candidate variable (1 = clause would become unsatisfied if that variable flips).
- Popcounts each mask in CHUNK_WIDTH-bit slices over several cycles, then selects the minimum-break candidate and flags the zero-break (freebie) case.
- Presents the result under a start/ready, valid/ack handshake to the flip controller.

Parameters:
- NUM_CLAUSES, 20, mask width per candidate.
- NUM_CANDIDATES, 3, number of candidate variables (rows) evaluated per request.
- CHUNK_WIDTH, 8, mask bits counted per candidate per cycle.
- NUM_CLAUSES_BITS, 5, break-value width; must satisfy 2^NUM_CLAUSES_BITS > NUM_CLAUSES.
- CAND_BITS, 2, index width; must satisfy 2^CAND_BITS >= NUM_CANDIDATES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  request strobe; accepted only when ready_o=1.
- clause_i  in  NUM_CANDIDATES*NUM_CLAUSES  flattened masks; candidate k occupies bits [k*NUM_CLAUSES +: NUM_CLAUSES].
- ack_i  in  1  consumer acknowledges the result.
- ready_o  out  1  high only in IDLE.
- valid_o  out  1  result valid; high only in DONE.
- break_values_o  out  NUM_CANDIDATES*NUM_CLAUSES_BITS  per-candidate break values, flattened the same way as clause_i.
- min_break_o  out  NUM_CLAUSES_BITS  minimum break value.
- min_idx_o  out  CAND_BITS  index of the minimum-break candidate.
- zero_break_o  out  1  min_break_o == 0.

Behaviour:
- Chunk count: NUM_CHUNKS = ceil(NUM_CLAUSES/CHUNK_WIDTH). The last chunk is zero-padded above NUM_CLAUSES.
- Reset: state=IDLE, ready_o=1, valid_o=0. All value outputs, accumulators and the chunk counter are 0.
- Reset asserted in any state aborts the operation and gives the same values on the next edge.
- FSM states: IDLE, COUNT, SELECT, DONE.
- IDLE:
  - On start_i=1, clause_i is latched into an internal register, accumulators and chunk counter are cleared, and the FSM enters COUNT.
  - clause_i is ignored after the accept edge.
- COUNT:
  - Each edge adds popcount(chunk c) of every candidate to its accumulator, then increments c.
  - After chunk NUM_CHUNKS-1 the FSM enters SELECT.
  - Accumulator width is NUM_CLAUSES_BITS; the sum cannot overflow given the parameter constraint.
- SELECT:
  - One edge. Registers break_values_o from the accumulators.
  - Registers min_break_o and min_idx_o using a strict less-than scan, so ties resolve to the lowest index.
  - Registers zero_break_o. Then enters DONE.
- DONE:
  - valid_o=1. Outputs hold stable while ack_i=0.
  - ack_i=1 returns the FSM to IDLE on the next edge.
- Latency: with the accept edge as edge 0, valid_o is high after edge NUM_CHUNKS+1. With the defaults that is after edge 4.
- Throughput: one request per NUM_CHUNKS+3 cycles minimum when ack_i is tied high.
- Outputs after ack:
  - break_values_o, min_break_o, min_idx_o and zero_break_o keep the last result in IDLE until the next SELECT.
  - They are not cleared at the next accept.
- Simultaneous events:
  - start_i while not IDLE is ignored; there is no queueing.
  - ack_i outside DONE is ignored.
  - start_i on the cycle after ack is accepted, because the FSM is in IDLE.
- NUM_CLAUSES an exact multiple of CHUNK_WIDTH: no padding. CHUNK_WIDTH >= NUM_CLAUSES: single COUNT cycle.

Test Plan:
- Reset then idle: ready_o=1, valid_o=0, all value outputs 0. Hold reset for 2 cycles mid-COUNT → same reset values on the next edge.
- Masks c0=0xFFFFF, c1=0x00001, c2=0x0F0F0:
  - valid_o rises exactly 4 edges after accept.
  - break_values = {8,1,20} (c2,c1,c0 order).
  - min_break_o=1, min_idx_o=1, zero_break_o=0.
- Masks c0=0x00300, c1=0x00000, c2=0x00000 → breaks {0,0,2}; min_break_o=0, min_idx_o=1 (tie to lowest), zero_break_o=1.
- All masks 0xFFFFF → all breaks 20; min_idx_o=0, zero_break_o=0.
- Backpressure:
  - Hold ack_i=0 for 10 cycles → valid_o and outputs stable, ready_o=0.
  - start_i pulses during busy are ignored, and the result is unchanged.
  - Change clause_i during COUNT → no effect on the result.
- Back-to-back:
  - ack_i tied high, second start_i issued the cycle after valid_o falls.
  - Second result correct; the first result is held through IDLE until the second SELECT.
  - Repeat both checks with CHUNK_WIDTH=20 and CHUNK_WIDTH=5 (latency 2 and 5).
